match_mem_ctrl: RTL

Memory controller driving the two-bank match memory (mem1/mem2 ports of the match SRAM wrapper). It writes an incoming keypoint/descriptor stream for the current frame into one bank. At frame end it sweeps every (current, previous) entry pair out of both banks to the brute-force matcher, then swaps the bank roles ping-pong style. It sits between the feature extractor (BRIEF/orientation stage) and the Hamming matcher.

---
 rtl/match_mem_ctrl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/match_mem_ctrl.sv
// Ping-pong controller for the two-bank match memory: fills the write bank with the
// current frame's features, then streams every (current, previous) entry pair to the matcher.
module match_mem_ctrl #(
  parameter int DEPTH  = 512,
  parameter int RD_LAT = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_feat_valid,
  output logic         o_feat_ready,
  input  logic [29:0]  i_feat_point,
  input  logic [255:0] i_feat_desc,
  input  logic         i_frame_end,
  output logic [10:0]  mem1_addr,
  output logic [285:0] mem1_wdata,
  output logic         mem1_wen,
  input  logic [285:0] mem1_rdata,
  output logic [10:0]  mem2_addr,
  output logic [285:0] mem2_wdata,
  output logic         mem2_wen,
  input  logic [285:0] mem2_rdata,
  output logic         o_pair_valid,
  output logic [29:0]  o_cur_point,
  output logic [29:0]  o_prev_point,
  output logic [255:0] o_cur_desc,
  output logic [255:0] o_prev_desc,
  output logic [8:0]   o_cur_idx,
  output logic [8:0]   o_prev_idx,
  output logic         o_row_last,
  output logic         o_sweep_last,
  output logic         o_frame_done,
  output logic         o_overflow
);

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_SWAP  = 2'd3;

  localparam int         TAG_W      = 21;
  localparam logic [9:0] DEPTH_C    = 10'(DEPTH);
  localparam logic [7:0] DRAIN_INIT = 8'(RD_LAT - 1);

  logic [1:0]   state_reg;
  logic         wsel_reg;
  logic         ready_reg;
  logic [9:0]   cur_cnt_reg;
  logic [9:0]   prev_cnt_reg;
  logic [8:0]   i_reg;
  logic [8:0]   j_reg;
  logic [7:0]   drain_reg;
  logic [10:0]  mem1_addr_reg;
  logic [10:0]  mem2_addr_reg;
  logic [285:0] mem1_wdata_reg;
  logic [285:0] mem2_wdata_reg;
  logic         mem1_wen_reg;
  logic         mem2_wen_reg;
  logic         frame_done_reg;
  logic         overflow_reg;
  logic [TAG_W-1:0] pair_tag_reg;

  logic         fill_active;
  logic         accept;
  logic         full;
  logic         do_write;
  logic         drop;
  logic [9:0]   cnt_after;
  logic         last_j;
  logic         last_i;
  logic         issue;
  logic [TAG_W-1:0] tag_in;
  logic [285:0] feat_word;
  logic [285:0] cur_rdata;
  logic [285:0] prev_rdata;

  always_comb begin
    fill_active = (state_reg == ST_FILL) && ready_reg;
    accept      = fill_active && i_feat_valid;
    full        = (cur_cnt_reg == DEPTH_C);
    do_write    = accept && !full;
    drop        = accept && full;
    cnt_after   = do_write ? cur_cnt_reg + 10'd1 : cur_cnt_reg;
    last_j      = ({1'b0, j_reg} == prev_cnt_reg - 10'd1);
    last_i      = ({1'b0, i_reg} == cur_cnt_reg - 10'd1);
    issue       = (state_reg == ST_SWEEP);
    tag_in      = {issue, i_reg, j_reg, last_j, last_j && last_i};
    feat_word   = {i_feat_point, i_feat_desc};
    cur_rdata   = wsel_reg ? mem2_rdata : mem1_rdata;
    prev_rdata  = wsel_reg ? mem1_rdata : mem2_rdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= ST_FILL;
      wsel_reg       <= 1'b0;
      ready_reg      <= 1'b0;
      cur_cnt_reg    <= '0;
      prev_cnt_reg   <= '0;
      i_reg          <= '0;
      j_reg          <= '0;
      drain_reg      <= '0;
      mem1_addr_reg  <= '0;
      mem2_addr_reg  <= '0;
      mem1_wdata_reg <= '0;
      mem2_wdata_reg <= '0;
      mem1_wen_reg   <= 1'b0;
      mem2_wen_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      mem1_wen_reg   <= 1'b0;
      mem2_wen_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
      overflow_reg   <= drop;
      case (state_reg)
        ST_FILL: begin
          ready_reg <= 1'b1;
          if (do_write) begin
            if (wsel_reg) begin
              mem2_addr_reg  <= {2'b00, cur_cnt_reg[8:0]};
              mem2_wdata_reg <= feat_word;
              mem2_wen_reg   <= 1'b1;
            end else begin
              mem1_addr_reg  <= {2'b00, cur_cnt_reg[8:0]};
              mem1_wdata_reg <= feat_word;
              mem1_wen_reg   <= 1'b1;
            end
            cur_cnt_reg <= cnt_after;
          end
          // A feature arriving with frame_end is the frame's last one, so the
          // sweep decision uses the count including it.
          if (fill_active && i_frame_end) begin
            ready_reg <= 1'b0;
            i_reg     <= '0;
            j_reg     <= '0;
            if (cnt_after != 10'd0 && prev_cnt_reg != 10'd0) begin
              state_reg <= ST_SWEEP;
            end else begin
              state_reg <= ST_SWAP;
            end
          end
        end
        ST_SWEEP: begin
          mem1_addr_reg  <= {2'b00, wsel_reg ? j_reg : i_reg};
          mem2_addr_reg  <= {2'b00, wsel_reg ? i_reg : j_reg};
          mem1_wdata_reg <= '0;
          mem2_wdata_reg <= '0;
          if (last_j) begin
            j_reg <= '0;
            if (last_i) begin
              state_reg <= ST_DRAIN;
              drain_reg <= DRAIN_INIT;
            end else begin
              i_reg <= i_reg + 9'd1;
            end
          end else begin
            j_reg <= j_reg + 9'd1;
          end
        end
        ST_DRAIN: begin
          if (drain_reg == 8'd0) begin
            state_reg <= ST_SWAP;
          end else begin
            drain_reg <= drain_reg - 8'd1;
          end
        end
        ST_SWAP: begin
          wsel_reg       <= ~wsel_reg;
          prev_cnt_reg   <= cur_cnt_reg;
          cur_cnt_reg    <= '0;
          frame_done_reg <= 1'b1;
          mem1_addr_reg  <= '0;
          mem2_addr_reg  <= '0;
          mem1_wdata_reg <= '0;
          mem2_wdata_reg <= '0;
          ready_reg      <= 1'b1;
          state_reg      <= ST_FILL;
        end
        default: state_reg <= ST_FILL;
      endcase
    end
  end

  // Tag pipeline tracks the SRAM read latency; the extra output register lines the
  // tag up with rdata, which appears RD_LAT cycles after the address is on the port.
  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_tag
      logic [TAG_W-1:0] tag_q;
      if (gi == 0) begin : g_head
        always_ff @(posedge i_clk) begin
          if (i_rst) tag_q <= '0;
          else       tag_q <= tag_in;
        end
      end else begin : g_body
        always_ff @(posedge i_clk) begin
          if (i_rst) tag_q <= '0;
          else       tag_q <= g_tag[gi-1].tag_q;
        end
      end
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) pair_tag_reg <= '0;
    else       pair_tag_reg <= g_tag[RD_LAT-1].tag_q;
  end

  assign o_feat_ready = ready_reg;
  assign mem1_addr    = mem1_addr_reg;
  assign mem2_addr    = mem2_addr_reg;
  assign mem1_wdata   = mem1_wdata_reg;
  assign mem2_wdata   = mem2_wdata_reg;
  assign mem1_wen     = mem1_wen_reg;
  assign mem2_wen     = mem2_wen_reg;
  assign o_frame_done = frame_done_reg;
  assign o_overflow   = overflow_reg;

  assign o_pair_valid = pair_tag_reg[20];
  assign o_cur_idx    = pair_tag_reg[19:11];
  assign o_prev_idx   = pair_tag_reg[10:2];
  assign o_row_last   = pair_tag_reg[1];
  assign o_sweep_last = pair_tag_reg[0];
  assign o_cur_point  = o_pair_valid ? cur_rdata[285:256]  : '0;
  assign o_cur_desc   = o_pair_valid ? cur_rdata[255:0]    : '0;
  assign o_prev_point = o_pair_valid ? prev_rdata[285:256] : '0;
  assign o_prev_desc  = o_pair_valid ? prev_rdata[255:0]   : '0;

endmodule
